// File: rtl/matmul_pkg.sv
// Shared types and default sizing for the matmul host sequencer.
// The row word is MAT_MUL_SIZE elements of DWIDTH bits, moved as one beat.
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_WR_FLUSH,
        ST_COMPUTE,
        ST_DRAIN,
        ST_DRAIN_FLUSH
    } seq_state_t;

    localparam int DEF_DWIDTH       = 8;
    localparam int DEF_MAT_MUL_SIZE = 32;
    localparam int ROW_W            = DEF_MAT_MUL_SIZE * DEF_DWIDTH;
    localparam int DEF_AWIDTH       = 7;
    localparam int DEF_NUM_ROWS     = 64;
    localparam int DEF_WR_ALIGN     = 2;
    localparam int DEF_RD_LAT       = 4;

    function automatic logic is_load(input seq_state_t s);
        return (s == ST_LOAD_A) || (s == ST_LOAD_B);
    endfunction

endpackage

// File: rtl/seq_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear.
// Used to align write data/strobes with the BRAM address and to time read valids.
module seq_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/matmul_host_sequencer.sv
// Host-side sequencer: loads A then B rows into the matmul BRAMs, runs the
// multiply until done_mat_mul, then streams the C rows back out.
module matmul_host_sequencer
    import matmul_pkg::*;
#(
    parameter int DWIDTH       = DEF_DWIDTH,
    parameter int MAT_MUL_SIZE = DEF_MAT_MUL_SIZE,
    parameter int AWIDTH       = DEF_AWIDTH,
    parameter int NUM_ROWS     = DEF_NUM_ROWS,
    parameter int WR_ALIGN     = DEF_WR_ALIGN,
    parameter int RD_LAT       = DEF_RD_LAT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] in_data,
    output logic                           out_valid,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
    output logic                           busy,
    output logic                           job_done,
    output logic                           enable_writing_to_mem,
    output logic                           enable_reading_from_mem,
    output logic [AWIDTH-1:0]              addr_pi,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] data_pi,
    output logic                           we_a,
    output logic                           we_b,
    output logic                           we_c,
    output logic                           start_mat_mul,
    input  logic                           done_mat_mul,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] data_from_out_mat
);

    localparam int RW    = MAT_MUL_SIZE * DWIDTH;
    // One extra bit so NUM_ROWS == 2^AWIDTH can be counted without aliasing.
    localparam int CNT_W = AWIDTH + 1;
    localparam int FL_W  = $clog2(WR_ALIGN + RD_LAT + 1) + 1;

    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_ROWS - 1);
    localparam logic [FL_W-1:0]  WR_LAST  = FL_W'(WR_ALIGN - 1);
    localparam logic [FL_W-1:0]  RD_LAST  = FL_W'(RD_LAT);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic             accept;
    logic [RW+1:0]    wr_dl_in;
    logic [RW+1:0]    wr_dl_out;
    logic             rd_dl_in;

    assign in_ready = is_load(state_q);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            row_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d                 = state_q;
        row_cnt_d               = row_cnt_q;
        flush_cnt_d             = flush_cnt_q;
        busy                    = (state_q != ST_IDLE);
        enable_writing_to_mem   = 1'b0;
        enable_reading_from_mem = 1'b0;
        start_mat_mul           = 1'b0;
        we_c                    = 1'b0;
        job_done                = 1'b0;
        addr_pi                 = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    state_d     = ST_LOAD_A;
                    row_cnt_d   = '0;
                    flush_cnt_d = '0;
                end
            end
            ST_LOAD_A, ST_LOAD_B: begin
                enable_writing_to_mem = 1'b1;
                addr_pi               = row_cnt_q[AWIDTH-1:0];
                if (accept) begin
                    if (row_cnt_q == LAST_ROW) begin
                        state_d     = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_WR_FLUSH;
                        row_cnt_d   = '0;
                        flush_cnt_d = '0;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            ST_WR_FLUSH: begin
                // Hold the write enable until the last delayed strobe has left.
                enable_writing_to_mem = 1'b1;
                if (flush_cnt_q == WR_LAST) begin
                    state_d     = ST_COMPUTE;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            ST_COMPUTE: begin
                start_mat_mul = 1'b1;
                we_c          = 1'b1;
                if (done_mat_mul) begin
                    state_d   = ST_DRAIN;
                    row_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                enable_reading_from_mem = 1'b1;
                addr_pi                 = row_cnt_q[AWIDTH-1:0];
                if (row_cnt_q == LAST_ROW) begin
                    state_d     = ST_DRAIN_FLUSH;
                    row_cnt_d   = '0;
                    flush_cnt_d = '0;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                end
            end
            ST_DRAIN_FLUSH: begin
                // RD_LAT cycles to empty the read pipe, then one cycle for job_done.
                enable_reading_from_mem = 1'b1;
                if (flush_cnt_q == RD_LAST) begin
                    job_done    = 1'b1;
                    state_d     = ST_IDLE;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign wr_dl_in = {(accept ? in_data : {RW{1'b0}}), accept, (state_q == ST_LOAD_B)};

    seq_delay_line #(
        .DEPTH (WR_ALIGN),
        .WIDTH (RW + 2)
    ) u_wr_delay (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (wr_dl_in),
        .q_o    (wr_dl_out)
    );

    assign data_pi = wr_dl_out[RW+1:2];
    assign we_a    = wr_dl_out[1] & ~wr_dl_out[0];
    assign we_b    = wr_dl_out[1] &  wr_dl_out[0];

    assign rd_dl_in = (state_q == ST_DRAIN);

    seq_delay_line #(
        .DEPTH (RD_LAT),
        .WIDTH (1)
    ) u_rd_delay (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (rd_dl_in),
        .q_o    (out_valid)
    );

    assign out_data = out_valid ? data_from_out_mat : {RW{1'b0}};

endmodule
